// File: rtl/uart_rx_tx_buffer_if.sv
// Handshake and status bundle between the UART cores and the rx->tx byte buffer.
// The buffer connects through the slave modport and the UART side through the master modport.
interface uart_rx_tx_buffer_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              rx_rdy;
    logic [7:0]        rx_data;
    logic              rx_rdy_clr;
    logic              tx_busy;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic [ADDR_W:0]   fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              overflow;
    logic              clr_overflow;
    logic [7:0]        drop_count;

    modport master (
        output rx_rdy, rx_data, tx_busy, clr_overflow,
        input  rx_rdy_clr, tx_start, tx_data, fifo_count, fifo_full, fifo_empty,
               overflow, drop_count
    );

    modport slave (
        input  rx_rdy, rx_data, tx_busy, clr_overflow,
        output rx_rdy_clr, tx_start, tx_data, fifo_count, fifo_full, fifo_empty,
               overflow, drop_count
    );
endinterface

// File: rtl/uart_rx_tx_buffer.sv
// Circular byte FIFO between the UART receiver and transmitter. Requests toward the slow
// baud-clocked cores are held as levels until the far side acknowledges them.
module uart_rx_tx_buffer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input logic              i_clk,
    input logic              i_rst,
    uart_rx_tx_buffer_if.slave bus
);
    localparam logic [ADDR_W:0] FullCnt = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        RxIdle,
        RxClr
    } rx_state_e;

    typedef enum logic [1:0] {
        TxIdle,
        TxReq,
        TxWait
    } tx_state_e;

    rx_state_e         r_rx_state, w_rx_state_d;
    tx_state_e         r_tx_state, w_tx_state_d;
    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [7:0]        r_tx_data;
    logic [7:0]        r_drop_count;
    logic              r_overflow;
    logic              w_full, w_empty, w_wr, w_drop, w_pop;

    assign w_full  = (r_count == FullCnt);
    assign w_empty = (r_count == '0);

    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    always_comb begin
        w_rx_state_d = r_rx_state;
        w_wr         = 1'b0;
        w_drop       = 1'b0;
        case (r_rx_state)
            RxIdle: begin
                if (bus.rx_rdy) begin
                    w_wr         = !w_full;
                    w_drop       = w_full;
                    w_rx_state_d = RxClr;
                end
            end
            RxClr: begin
                if (!bus.rx_rdy) w_rx_state_d = RxIdle;
            end
            default: w_rx_state_d = RxIdle;
        endcase
    end

    always_comb begin
        w_tx_state_d = r_tx_state;
        w_pop        = 1'b0;
        case (r_tx_state)
            TxIdle: begin
                if (!w_empty && !bus.tx_busy) begin
                    w_pop        = 1'b1;
                    w_tx_state_d = TxReq;
                end
            end
            TxReq: begin
                if (bus.tx_busy) w_tx_state_d = TxWait;
            end
            TxWait: begin
                if (!bus.tx_busy) w_tx_state_d = TxIdle;
            end
            default: w_tx_state_d = TxIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_state   <= RxIdle;
            r_tx_state   <= TxIdle;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_tx_data    <= 8'h00;
            r_overflow   <= 1'b0;
            r_drop_count <= 8'h00;
        end else begin
            r_rx_state <= w_rx_state_d;
            r_tx_state <= w_tx_state_d;
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_tx_data <= r_mem[r_rd_ptr];
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A drop coinciding with a clear restarts the tally at one.
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (bus.clr_overflow)          r_drop_count <= 8'd1;
                else if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 1'b1;
            end else if (bus.clr_overflow) begin
                r_overflow   <= 1'b0;
                r_drop_count <= 8'h00;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= bus.rx_data;
    end

    assign bus.rx_rdy_clr = (r_rx_state == RxClr);
    assign bus.tx_start   = (r_tx_state == TxReq);
    assign bus.tx_data    = r_tx_data;
    assign bus.fifo_count = r_count;
    assign bus.fifo_full  = w_full;
    assign bus.fifo_empty = w_empty;
    assign bus.overflow   = r_overflow;
    assign bus.drop_count = r_drop_count;
endmodule
